// File: rtl/clk_tick_gate_if.sv
// Handshake bundle between the tick source side and the tick gate.
// The master drives the divided clock, the mode and the button; the slave returns the CPU enable and the counters.
interface clk_tick_gate_if #(
  parameter int CNT_W = 32
);
  logic             tick_in;
  logic [1:0]       mode;
  logic             step_btn;
  logic             clr_cnt;
  logic             cpu_en;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] tick_period;
  logic             period_valid;

  modport master (
    output tick_in, mode, step_btn, clr_cnt,
    input  cpu_en, edge_cnt, tick_period, period_valid
  );

  modport slave (
    input  tick_in, mode, step_btn, clr_cnt,
    output cpu_en, edge_cnt, tick_period, period_valid
  );
endinterface

// File: rtl/clk_tick_gate.sv
// Turns rising edges of an asynchronous divided clock into one-cycle CPU enable pulses.
// Supports RUN, PAUSE and debounced single-step modes, and measures the tick period.
module clk_tick_gate #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = 20,
  parameter int CNT_W       = 32
) (
  input  logic            clk_in,
  input  logic            rst_n,
  clk_tick_gate_if.slave  bus
);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam logic [1:0] M_RUN  = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;

  typedef enum logic [2:0] {
    ST_PAUSE,
    ST_RUN,
    ST_STEP_IDLE,
    ST_STEP_PEND,
    ST_STEP_HOLD
  } state_t;

  logic [SYNC_STAGES-1:0] tick_sync_q;
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic                   tick_prev_q;
  logic                   rise;
  logic                   btn_s;

  logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
  logic                   deb_q, deb_d;
  logic                   press;

  state_t                 state_q;
  logic                   cpu_en_q;
  logic [CNT_W-1:0]       edge_cnt_q;
  logic [CNT_W-1:0]       per_cnt_q, per_cnt_inc;
  logic [CNT_W-1:0]       tick_period_q;
  logic                   period_valid_q;
  logic                   seen_rise_q;

  // Synchronizer chains: bit 0 samples the raw input, the top bit is the safe copy.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_sync_q <= '0;
      btn_sync_q  <= '0;
      tick_prev_q <= 1'b0;
    end else begin
      tick_sync_q <= {tick_sync_q[SYNC_STAGES-2:0], bus.tick_in};
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], bus.step_btn};
      tick_prev_q <= tick_sync_q[SYNC_STAGES-1];
    end
  end

  assign rise  = tick_sync_q[SYNC_STAGES-1] & ~tick_prev_q;
  assign btn_s = btn_sync_q[SYNC_STAGES-1];

  // Debounce: the level flips only after DEB_CNT consecutive disagreeing cycles.
  always_comb begin
    deb_cnt_d = '0;
    deb_d     = deb_q;
    if (btn_s != deb_q) begin
      if (deb_cnt_q == DW'(DEB_CNT - 1)) deb_d = btn_s;
      else                               deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  assign press = deb_d & ~deb_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      deb_q     <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_q     <= deb_d;
    end
  end

  // Mode FSM with registered enable; pulses only ever come from a single-cycle rise.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_PAUSE;
      cpu_en_q <= 1'b0;
    end else begin
      cpu_en_q <= 1'b0;
      case (bus.mode)
        M_RUN: begin
          cpu_en_q <= (state_q == ST_RUN) & rise;
          state_q  <= ST_RUN;
        end
        M_STEP: begin
          case (state_q)
            ST_STEP_IDLE: begin
              if (press & rise) begin
                cpu_en_q <= 1'b1;
                state_q  <= ST_STEP_HOLD;
              end else if (press) begin
                state_q  <= ST_STEP_PEND;
              end
            end
            ST_STEP_PEND: begin
              if (rise) begin
                cpu_en_q <= 1'b1;
                state_q  <= ST_STEP_HOLD;
              end
            end
            ST_STEP_HOLD: begin
              if (!deb_q) state_q <= ST_STEP_IDLE;
            end
            default: state_q <= ST_STEP_IDLE;
          endcase
        end
        default: state_q <= ST_PAUSE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)            edge_cnt_q <= '0;
    else if (bus.clr_cnt)  edge_cnt_q <= '0;
    else if (cpu_en_q)     edge_cnt_q <= edge_cnt_q + CNT_W'(1);
  end

  assign per_cnt_inc = (&per_cnt_q) ? per_cnt_q : per_cnt_q + CNT_W'(1);

  // The first rise only aligns the counter; real measurements start with the second.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q      <= '0;
      tick_period_q  <= '0;
      period_valid_q <= 1'b0;
      seen_rise_q    <= 1'b0;
    end else if (rise) begin
      per_cnt_q   <= '0;
      seen_rise_q <= 1'b1;
      if (seen_rise_q) begin
        tick_period_q  <= per_cnt_inc;
        period_valid_q <= 1'b1;
      end
    end else begin
      per_cnt_q <= per_cnt_inc;
    end
  end

  assign bus.cpu_en       = cpu_en_q;
  assign bus.edge_cnt     = edge_cnt_q;
  assign bus.tick_period  = tick_period_q;
  assign bus.period_valid = period_valid_q;
endmodule
